// File: rtl/stage_sum_pwm_pkg.sv
// Shared widths and the sign/magnitude-to-two's-complement helper for the
// three-term summing pipeline.
package stage_sum_pwm_pkg;

  localparam int unsigned TERM_W = 16;
  localparam int unsigned SUM_W  = 19;
  localparam int unsigned PART_W = TERM_W + 2;
  localparam logic [7:0]  SatCntMax = 8'hFF;

  // sgn = 1 adds the magnitude, sgn = 0 subtracts it; -0 collapses to 0.
  function automatic logic signed [TERM_W:0] term_to_signed(input logic [TERM_W-1:0] mag,
                                                            input logic              sgn);
    logic signed [TERM_W:0] ext;
    ext = $signed({1'b0, mag});
    return sgn ? ext : -ext;
  endfunction

endpackage

// File: rtl/stage_sum_pwm_pwm_gen.sv
// Free-running PWM: a staged duty value is taken up only at the period wrap
// so a period is never altered mid-way.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [PWM_BITS-1:0] duty_in_i,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] CntMax = '1;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_next_q, duty_next_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    cnt_d       = cnt_q + PWM_BITS'(1);
    duty_next_d = load_i ? duty_in_i : duty_next_q;
    // A load in the wrap cycle lands in duty_next too late; the old value wins.
    duty_d      = (cnt_q == CntMax) ? duty_next_q : duty_q;
    pwm_d       = (cnt_q < duty_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      duty_q      <= '0;
      duty_next_q <= '0;
      pwm_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      duty_next_q <= duty_next_d;
      pwm_q       <= pwm_d;
    end
  end

  assign duty_o = duty_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/stage_sum_pwm.sv
// Two-stage signed sum of three sign/magnitude terms, clamped to 16 bits and
// used to drive a period-synchronous PWM.
module stage_sum_pwm
  import stage_sum_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [TERM_W-1:0]        c0,
  input  logic [TERM_W-1:0]        c1,
  input  logic [TERM_W-1:0]        c2,
  input  logic                     c0sgn,
  input  logic                     c1sgn,
  input  logic                     c2sgn,
  output logic signed [SUM_W-1:0]  sum,
  output logic                     sum_valid,
  output logic [PWM_BITS-1:0]      duty,
  output logic                     pwm,
  output logic                     sat,
  output logic [7:0]               sat_cnt
);

  logic signed [TERM_W:0]   term0, term1, term2;
  logic signed [PART_W-1:0] partial_d, partial_q;
  logic signed [TERM_W:0]   term2_q;
  logic                     p1_valid_q;
  logic signed [SUM_W-1:0]  sum_d, sum_q;
  logic                     sum_valid_q;
  logic [PWM_BITS-1:0]      duty_cand_d, duty_cand_q;
  logic                     clamp_hit;
  logic                     sat_d, sat_q;
  logic [7:0]               sat_cnt_d, sat_cnt_q;

  always_comb begin
    term0     = term_to_signed(c0, c0sgn);
    term1     = term_to_signed(c1, c1sgn);
    term2     = term_to_signed(c2, c2sgn);
    partial_d = {term0[TERM_W], term0} + {term1[TERM_W], term1};
  end

  always_comb begin
    sum_d       = {partial_q[PART_W-1], partial_q} + {{2{term2_q[TERM_W]}}, term2_q};
    clamp_hit   = 1'b0;
    duty_cand_d = sum_d[TERM_W-1 -: PWM_BITS];
    // Negative clamps to 0, anything above 16 bits clamps to 0xFFFF.
    if (sum_d[SUM_W-1]) begin
      clamp_hit   = 1'b1;
      duty_cand_d = '0;
    end else if (|sum_d[SUM_W-2:TERM_W]) begin
      clamp_hit   = 1'b1;
      duty_cand_d = '1;
    end
    sat_d     = p1_valid_q & clamp_hit;
    sat_cnt_d = (sat_d && (sat_cnt_q != SatCntMax)) ? sat_cnt_q + 8'd1 : sat_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      partial_q   <= '0;
      term2_q     <= '0;
      p1_valid_q  <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      duty_cand_q <= '0;
      sat_q       <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      p1_valid_q  <= in_valid;
      sum_valid_q <= p1_valid_q;
      sat_q       <= sat_d;
      sat_cnt_q   <= sat_cnt_d;
      if (in_valid) begin
        partial_q <= partial_d;
        term2_q   <= term2;
      end
      if (p1_valid_q) begin
        sum_q       <= sum_d;
        duty_cand_q <= duty_cand_d;
      end
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (sum_valid_q),
    .duty_in_i (duty_cand_q),
    .duty_o    (duty),
    .pwm_o     (pwm)
  );

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign sat       = sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_stage_sum_pwm.sv
// Directed bench for stage_sum_pwm with PWM_BITS = 8.
module tb_stage_sum_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] c0 = '0, c1 = '0, c2 = '0;
  logic        c0sgn = 1'b1, c1sgn = 1'b1, c2sgn = 1'b1;
  logic [18:0] sum_w;
  logic        sum_valid, pwm, sat;
  logic [7:0]  duty, sat_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_cnt;

  stage_sum_pwm #(
    .PWM_BITS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c0sgn     (c0sgn),
    .c1sgn     (c1sgn),
    .c2sgn     (c2sgn),
    .sum       (sum_w),
    .sum_valid (sum_valid),
    .duty      (duty),
    .pwm       (pwm),
    .sat       (sat),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  // Reference period counter: equals the PWM counter after each edge.
  always @(posedge clk) begin
    if (rst) m_cnt <= '0;
    else     m_cnt <= m_cnt + 8'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [15:0] a, input logic as, input logic [15:0] b,
                       input logic bs, input logic [15:0] c, input logic cs);
    c0 = a; c0sgn = as; c1 = b; c1sgn = bs; c2 = c; c2sgn = cs;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_cnt(input logic [7:0] target);
    for (int i = 0; i < 600 && m_cnt != target; i++) step();
    checks++;
    if (m_cnt !== target) begin
      errors++;
      $display("FAIL wait_cnt: got %0d required %0d", m_cnt, target);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (256) begin
      step();
      if (pwm === 1'b1) n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sum_w, sum_valid, sat, sat_cnt, duty, pwm} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sum=%h sv=%b sat=%b sc=%0d duty=%h pwm=%b required all 0",
               sum_w, sum_valid, sat, sat_cnt, duty, pwm);
    end
  endtask

  task automatic test_half();
    int n;
    do_reset();
    drive(16'h8000, 1'b1, 16'h0, 1'b1, 16'h0, 1'b1);
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++; $display("FAIL half_latency1: got sv=%b required 0", sum_valid);
    end
    step();
    checks++;
    if (sum_valid !== 1'b1 || sum_w !== 19'h08000 || sat !== 1'b0) begin
      errors++;
      $display("FAIL half_sum: got sv=%b sum=%h sat=%b required 1 08000 0", sum_valid, sum_w, sat);
    end
    checks++;
    if (duty !== 8'h00) begin
      errors++; $display("FAIL half_duty_before_wrap: got %h required 00", duty);
    end
    wait_cnt(8'd0);
    checks++;
    if (duty !== 8'h80) begin
      errors++; $display("FAIL half_duty: got %h required 80", duty);
    end
    count_high(n);
    checks++;
    if (n != 128) begin
      errors++; $display("FAIL half_pwm_high: got %0d required 128", n);
    end
  endtask

  task automatic test_negative();
    int n;
    do_reset();
    drive(16'h0010, 1'b0, 16'h0005, 1'b1, 16'h0, 1'b1);
    step();
    checks++;
    if (sum_valid !== 1'b1 || sum_w !== 19'h7FFF5 || sat !== 1'b1 || sat_cnt !== 8'd1) begin
      errors++;
      $display("FAIL neg_sum: got sv=%b sum=%h sat=%b sc=%0d required 1 7fff5 1 1",
               sum_valid, sum_w, sat, sat_cnt);
    end
    step();
    checks++;
    if (sat !== 1'b0 || sum_valid !== 1'b0) begin
      errors++; $display("FAIL neg_pulse: got sat=%b sv=%b required 0 0", sat, sum_valid);
    end
    wait_cnt(8'd0);
    count_high(n);
    checks++;
    if (duty !== 8'h00 || n != 0) begin
      errors++; $display("FAIL neg_pwm: got duty=%h high=%0d required 00 0", duty, n);
    end
  endtask

  task automatic test_max();
    int n;
    do_reset();
    drive(16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    step();
    checks++;
    if (sum_valid !== 1'b1 || sum_w !== 19'h2FFFD || sat !== 1'b1) begin
      errors++;
      $display("FAIL max_sum: got sv=%b sum=%h sat=%b required 1 2fffd 1", sum_valid, sum_w, sat);
    end
    wait_cnt(8'd0);
    checks++;
    if (duty !== 8'hFF) begin
      errors++; $display("FAIL max_duty: got %h required ff", duty);
    end
    count_high(n);
    checks++;
    if (n != 255) begin
      errors++; $display("FAIL max_pwm_high: got %0d required 255", n);
    end
  endtask

  task automatic test_last_wins();
    int n;
    do_reset();
    wait_cnt(8'd10);
    drive(16'h1000, 1'b1, 16'h0, 1'b1, 16'h0, 1'b1);
    wait_cnt(8'd20);
    drive(16'h2000, 1'b1, 16'h0, 1'b1, 16'h0, 1'b1);
    wait_cnt(8'd253);
    drive(16'h3000, 1'b1, 16'h0, 1'b1, 16'h0, 1'b1);
    step();
    checks++;
    if (sum_valid !== 1'b1 || sum_w !== 19'h03000 || m_cnt !== 8'd255) begin
      errors++;
      $display("FAIL wrap_valid: got sv=%b sum=%h cnt=%0d required 1 03000 255",
               sum_valid, sum_w, m_cnt);
    end
    step();
    checks++;
    if (duty !== 8'h20) begin
      errors++; $display("FAIL wrap_old_duty: got %h required 20", duty);
    end
    count_high(n);
    checks++;
    if (n != 32) begin
      errors++; $display("FAIL wrap_pwm_high: got %0d required 32", n);
    end
    checks++;
    if (duty !== 8'h30) begin
      errors++; $display("FAIL wrap_new_duty: got %h required 30", duty);
    end
  endtask

  task automatic test_reset_flush();
    logic seen;
    do_reset();
    drive(16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (sum_valid !== 1'b0 || sat !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_valid: got pulse=%b required 0", seen);
    end
    checks++;
    if ({sum_w, sat_cnt, duty, pwm} !== '0) begin
      errors++;
      $display("FAIL flush_outputs: got sum=%h sc=%0d duty=%h pwm=%b required all 0",
               sum_w, sat_cnt, duty, pwm);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4] = '{16'h0001, 16'h0100, 16'hFFFF, 16'h0000};
    logic        sa [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] vb [4] = '{16'h0002, 16'h0000, 16'hFFFF, 16'h0000};
    logic        sb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] vc [4] = '{16'h0003, 16'h0050, 16'h1234, 16'h0000};
    logic        sc [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [18:0] es [4] = '{19'h00006, 19'h7FF50, 19'h01234, 19'h00000};
    logic        et [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i < 6) begin
        checks++;
        if (sum_valid !== 1'b1 || sum_w !== es[i-2] || sat !== et[i-2]) begin
          errors++;
          $display("FAIL b2b_%0d: got sv=%b sum=%h sat=%b required 1 %h %b",
                   i - 2, sum_valid, sum_w, sat, es[i-2], et[i-2]);
        end
      end else if (i == 6) begin
        checks++;
        if (sum_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_end: got sv=%b required 0", sum_valid);
        end
      end
      if (i < 4) begin
        c0 = va[i]; c0sgn = sa[i]; c1 = vb[i]; c1sgn = sb[i]; c2 = vc[i]; c2sgn = sc[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_sat_cnt();
    int nv = 0;
    int ns = 0;
    do_reset();
    c0 = 16'h0001; c0sgn = 1'b0;
    c1 = 16'h0000; c1sgn = 1'b1;
    c2 = 16'h0000; c2sgn = 1'b1;
    for (int i = 0; i < 304; i++) begin
      in_valid = (i < 300);
      step();
      if (sum_valid === 1'b1) nv++;
      if (sat === 1'b1) begin
        ns++;
        if (ns == 100) begin
          checks++;
          if (sat_cnt !== 8'd100) begin
            errors++; $display("FAIL satcnt_100: got %0d required 100", sat_cnt);
          end
        end
      end
    end
    checks++;
    if (nv != 300 || ns != 300) begin
      errors++; $display("FAIL satcnt_pulses: got valid=%0d sat=%0d required 300 300", nv, ns);
    end
    checks++;
    if (sat_cnt !== 8'd255) begin
      errors++; $display("FAIL satcnt_hold: got %0d required 255", sat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_negative();
    test_max();
    test_last_wins();
    test_reset_flush();
    test_back_to_back();
    test_sat_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
